// File: rtl/iod_dly_train_pkg.sv
// Shared types and constants for the IOD delay-line training sequencer.
package iod_dly_train_pkg;

    localparam int unsigned TAP_W = 8;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StSettle,
        StClear,
        StSample,
        StEval,
        StStep,
        StReturn,
        StRestore,
        StDone
    } train_state_e;

endpackage

// File: rtl/iod_dly_train_ctrl_if.sv
// Training handshake plus IOD delay-line / eye-monitor pins of one lane.
interface iod_dly_train_ctrl_if;
    import iod_dly_train_pkg::*;

    logic             train_req;
    logic             train_busy;
    logic             train_done;
    logic             train_fail;
    logic [TAP_W-1:0] tap_center;
    logic [TAP_W-1:0] tap_current;
    logic             delay_line_load;
    logic             delay_line_move;
    logic             delay_line_direction;
    logic             eye_monitor_clear_flags;
    logic             eye_monitor_early;
    logic             eye_monitor_late;
    logic             delay_line_out_of_range;

    // Controller side.
    modport slave (
        input  train_req,
        input  eye_monitor_early,
        input  eye_monitor_late,
        input  delay_line_out_of_range,
        output train_busy,
        output train_done,
        output train_fail,
        output tap_center,
        output tap_current,
        output delay_line_load,
        output delay_line_move,
        output delay_line_direction,
        output eye_monitor_clear_flags
    );

    // PHY training FSM plus IOD side.
    modport master (
        output train_req,
        output eye_monitor_early,
        output eye_monitor_late,
        output delay_line_out_of_range,
        input  train_busy,
        input  train_done,
        input  train_fail,
        input  tap_center,
        input  tap_current,
        input  delay_line_load,
        input  delay_line_move,
        input  delay_line_direction,
        input  eye_monitor_clear_flags
    );

endinterface

// File: rtl/iod_eye_window_sampler.sv
// Observes the eye-monitor flags for SAMPLE_CYC cycles after a start pulse and
// keeps a sticky OR of early/late/out-of-range over that window.
module iod_eye_window_sampler #(
    parameter int unsigned SAMPLE_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic start_i,
    input  logic early_i,
    input  logic late_i,
    input  logic oor_i,
    output logic pass_o,
    output logic oor_o,
    output logic done_o
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic             early_q;
    logic             late_q;
    logic             oor_q;

    // Window counter and sticky flags; start restarts the window with clean flags.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            oor_q    <= 1'b0;
        end else if (start_i) begin
            cnt_q    <= CNT_W'(SAMPLE_CYC);
            active_q <= 1'b1;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            oor_q    <= 1'b0;
        end else if (active_q) begin
            early_q <= early_q | early_i;
            late_q  <= late_q | late_i;
            oor_q   <= oor_q | oor_i;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                active_q <= 1'b0;
            end
        end
    end

    // done_o marks the last observation cycle; flags are final one cycle later.
    assign done_o = active_q && (cnt_q == CNT_W'(1));
    assign pass_o = !early_q && !late_q && !oor_q;
    assign oor_o  = oor_q;

endmodule

// File: rtl/iod_dly_train_ctrl.sv
// Per-lane delay-line training sequencer: sweeps the delay line upward, finds
// the first contiguous passing window and walks the line back to its centre.
module iod_dly_train_ctrl
    import iod_dly_train_pkg::*;
#(
    parameter int unsigned MAX_TAPS   = 128,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned SAMPLE_CYC = 16,
    parameter int unsigned MIN_EYE    = 4
) (
    input logic                 fab_clk,
    input logic                 sync_rst,
    iod_dly_train_ctrl_if.slave bus
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(MAX_TAPS - 1);
    localparam logic [TAP_W:0] MIN_EYE_W = (TAP_W + 1)'(MIN_EYE);

    train_state_e     state_q;
    train_state_e     settle_next_q;
    logic [SET_W-1:0] settle_cnt_q;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] start_q;
    logic [TAP_W-1:0] center_q;
    logic             found_q;
    logic             busy_q;
    logic             done_q;
    logic             fail_q;
    logic [TAP_W-1:0] tap_center_q;
    logic             load_q;
    logic             move_q;
    logic             dir_q;
    logic             clr_q;
    logic             smp_clear_q;
    logic             smp_start_q;

    logic smp_pass;
    logic smp_oor;
    logic smp_done;

    iod_eye_window_sampler #(
        .SAMPLE_CYC(SAMPLE_CYC)
    ) u_sampler (
        .clk_i  (fab_clk),
        .rst_i  (sync_rst),
        .clear_i(smp_clear_q),
        .start_i(smp_start_q),
        .early_i(bus.eye_monitor_early),
        .late_i (bus.eye_monitor_late),
        .oor_i  (bus.delay_line_out_of_range),
        .pass_o (smp_pass),
        .oor_o  (smp_oor),
        .done_o (smp_done)
    );

    logic             eval_found;
    logic             eval_ret;
    logic             eval_restore;
    logic             eval_narrow;
    logic [TAP_W-1:0] eval_start;
    logic [TAP_W-1:0] eval_end;
    logic [TAP_W-1:0] eval_center;
    logic [TAP_W:0]   eval_width;

    // Per-tap verdict: window bookkeeping and where the sweep goes next.
    always_comb begin
        eval_found   = found_q | smp_pass;
        eval_start   = (found_q || !smp_pass) ? start_q : tap_q;
        eval_end     = tap_q;
        eval_ret     = 1'b0;
        eval_restore = 1'b0;
        if (!smp_pass && found_q) begin
            eval_end = tap_q - TAP_W'(1);
            eval_ret = 1'b1;
        end else if (smp_oor || (tap_q == LAST_TAP)) begin
            if (eval_found) begin
                eval_end = smp_pass ? tap_q : tap_q - TAP_W'(1);
                eval_ret = 1'b1;
            end else begin
                eval_restore = 1'b1;
            end
        end
        // Width kept one bit wider so a full 256-tap window does not wrap to 0.
        eval_width  = {1'b0, eval_end - eval_start} + (TAP_W + 1)'(1);
        eval_narrow = eval_width < MIN_EYE_W;
        eval_center = eval_start + ((eval_end - eval_start) >> 1);
    end

    // Training FSM with all IOD pulses and status outputs registered.
    always_ff @(posedge fab_clk) begin
        if (sync_rst) begin
            state_q       <= StIdle;
            settle_next_q <= StIdle;
            settle_cnt_q  <= '0;
            tap_q         <= '0;
            start_q       <= '0;
            center_q      <= '0;
            found_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            tap_center_q  <= '0;
            load_q        <= 1'b0;
            move_q        <= 1'b0;
            dir_q         <= 1'b0;
            clr_q         <= 1'b0;
            smp_clear_q   <= 1'b0;
            smp_start_q   <= 1'b0;
        end else begin
            load_q      <= 1'b0;
            move_q      <= 1'b0;
            clr_q       <= 1'b0;
            done_q      <= 1'b0;
            smp_clear_q <= 1'b0;
            smp_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.train_req) begin
                        state_q     <= StLoad;
                        busy_q      <= 1'b1;
                        fail_q      <= 1'b0;
                        load_q      <= 1'b1;
                        smp_clear_q <= 1'b1;
                        tap_q       <= '0;
                        start_q     <= '0;
                        found_q     <= 1'b0;
                    end
                end
                StLoad, StStep: begin
                    state_q       <= StSettle;
                    settle_next_q <= StClear;
                    settle_cnt_q  <= SETTLE_LAST;
                end
                StSettle: begin
                    if (settle_next_q == StReturn && bus.delay_line_out_of_range) begin
                        state_q      <= StRestore;
                        load_q       <= 1'b1;
                        tap_q        <= '0;
                        tap_center_q <= '0;
                        fail_q       <= 1'b1;
                    end else if (settle_cnt_q != '0) begin
                        settle_cnt_q <= settle_cnt_q - SET_W'(1);
                    end else begin
                        case (settle_next_q)
                            StClear: begin
                                state_q     <= StClear;
                                clr_q       <= 1'b1;
                                smp_start_q <= 1'b1;
                            end
                            StReturn: begin
                                if (tap_q == center_q) begin
                                    state_q      <= StDone;
                                    done_q       <= 1'b1;
                                    tap_center_q <= center_q;
                                    fail_q       <= 1'b0;
                                end else begin
                                    state_q <= StReturn;
                                    move_q  <= 1'b1;
                                    dir_q   <= DIR_DEC;
                                    tap_q   <= tap_q - TAP_W'(1);
                                end
                            end
                            default: begin
                                // Only the restore path settles into DONE.
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                StClear: begin
                    state_q <= StSample;
                end
                StSample: begin
                    if (smp_done) begin
                        state_q <= StEval;
                    end
                end
                StEval: begin
                    start_q <= eval_start;
                    found_q <= eval_found;
                    if (eval_ret && !eval_narrow) begin
                        center_q <= eval_center;
                        if (tap_q == eval_center) begin
                            state_q      <= StDone;
                            done_q       <= 1'b1;
                            tap_center_q <= eval_center;
                            fail_q       <= 1'b0;
                        end else begin
                            state_q <= StReturn;
                            move_q  <= 1'b1;
                            dir_q   <= DIR_DEC;
                            tap_q   <= tap_q - TAP_W'(1);
                        end
                    end else if (eval_ret || eval_restore) begin
                        state_q      <= StRestore;
                        load_q       <= 1'b1;
                        tap_q        <= '0;
                        tap_center_q <= '0;
                        fail_q       <= 1'b1;
                    end else begin
                        state_q <= StStep;
                        move_q  <= 1'b1;
                        dir_q   <= DIR_INC;
                        tap_q   <= tap_q + TAP_W'(1);
                    end
                end
                StReturn: begin
                    if (bus.delay_line_out_of_range) begin
                        state_q      <= StRestore;
                        load_q       <= 1'b1;
                        tap_q        <= '0;
                        tap_center_q <= '0;
                        fail_q       <= 1'b1;
                    end else begin
                        state_q       <= StSettle;
                        settle_next_q <= StReturn;
                        settle_cnt_q  <= SETTLE_LAST;
                    end
                end
                StRestore: begin
                    state_q       <= StSettle;
                    settle_next_q <= StDone;
                    settle_cnt_q  <= SETTLE_LAST;
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.train_busy              = busy_q;
    assign bus.train_done              = done_q;
    assign bus.train_fail              = fail_q;
    assign bus.tap_center              = tap_center_q;
    assign bus.tap_current             = tap_q;
    assign bus.delay_line_load         = load_q;
    assign bus.delay_line_move         = move_q;
    assign bus.delay_line_direction    = dir_q;
    assign bus.eye_monitor_clear_flags = clr_q;

endmodule
